// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the LC-3b decode hazard scoreboard.
package regfile_scoreboard_pkg;

  // Pointer/count width; covers queue depths up to 7.
  localparam int SB_PTR_W = 3;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic    wr;
    lc3b_reg dest;
  } sb_entry_t;

  // Advance a ring pointer by n (n <= depth), wrapping at depth.
  function automatic logic [SB_PTR_W-1:0] sb_ptr_add(input logic [SB_PTR_W-1:0] p,
                                                     input int unsigned n,
                                                     input int unsigned depth);
    int unsigned s;
    s = int'(p) + n;
    if (s >= depth) s = s - depth;
    return SB_PTR_W'(s);
  endfunction

  // Move a ring pointer back by n (n <= depth), wrapping at depth.
  function automatic logic [SB_PTR_W-1:0] sb_ptr_sub(input logic [SB_PTR_W-1:0] p,
                                                     input int unsigned n,
                                                     input int unsigned depth);
    int unsigned s;
    s = int'(p) + depth - n;
    if (s >= depth) s = s - depth;
    return SB_PTR_W'(s);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_queue.sv
// Circular buffer of in-flight instructions: push at tail, pop at head,
// drop up to three youngest entries from the tail. Validity of each slot is
// derived from head and count, so stored entries need no reset.
module sb_queue
  import regfile_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_push,
  input  sb_entry_t                   i_entry,
  input  logic                        i_pop,
  input  logic [1:0]                  i_drop,
  output sb_entry_t [DEPTH-1:0]       o_entries,
  output logic      [DEPTH-1:0]       o_valid,
  output logic      [SB_PTR_W-1:0]    o_head,
  output logic      [SB_PTR_W-1:0]    o_count
);

  sb_entry_t             r_mem [2**SB_PTR_W];
  logic [SB_PTR_W-1:0]   r_head;
  logic [SB_PTR_W-1:0]   r_tail;
  logic [SB_PTR_W-1:0]   r_count;
  logic [SB_PTR_W-1:0]   w_tail_drop;
  logic [SB_PTR_W-1:0]   w_tail_next;
  logic [SB_PTR_W-1:0]   w_head_next;
  logic [SB_PTR_W-1:0]   w_count_next;

  // Next pointers: the tail is first pulled back by the drop, then a push lands there.
  always_comb begin
    w_tail_drop  = sb_ptr_sub(r_tail, int'(i_drop), DEPTH);
    w_tail_next  = i_push ? sb_ptr_add(w_tail_drop, 1, DEPTH) : w_tail_drop;
    w_head_next  = i_pop ? sb_ptr_add(r_head, 1, DEPTH) : r_head;
    w_count_next = r_count + SB_PTR_W'(i_push) - SB_PTR_W'(i_pop) - SB_PTR_W'(i_drop);
  end

  // Control state: pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // Entry storage: written on push only.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_tail_drop] <= i_entry;
  end

  // Expose slots with a valid bit from their age relative to head.
  always_comb begin
    int unsigned w_off;
    w_off     = 0;
    o_entries = '0;
    o_valid   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i] = r_mem[i];
      w_off = (i >= int'(r_head)) ? (i - int'(r_head)) : (i + DEPTH - int'(r_head));
      o_valid[i] = (w_off < int'(r_count));
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// In-order hazard scoreboard for the LC-3b decode stage.
// Optional feature macro: SB_WB_BYPASS_EN (an entry retiring this cycle no
// longer blocks readers, relying on regfile write-through).
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] src_a,
  input  logic       src_a_used,
  input  logic [2:0] src_b,
  input  logic       src_b_used,
  input  logic [2:0] dest,
  input  logic       dest_wr,
  input  logic       issue_req,
  input  logic       pipe_stall,
  input  logic       wb_retire,
  input  logic       flush,
  input  logic [1:0] flush_cnt,
  output logic       issue_ok,
  output logic       stall_decode,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic       err
);

`ifdef SB_WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  sb_entry_t [DEPTH-1:0]  w_entries;
  logic [DEPTH-1:0]       w_valid;
  logic [SB_PTR_W-1:0]    w_head;
  logic [SB_PTR_W-1:0]    w_count;
  logic [SB_PTR_W-1:0]    w_remain;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_retire;
  logic                   w_flush;
  logic                   w_clamp;
  logic [1:0]             w_drop;
  logic                   w_hazard;
  logic                   w_issue;
  logic                   w_err_set;
  logic                   r_err;
  sb_entry_t              w_push_entry;

  assign w_full  = (w_count == SB_PTR_W'(DEPTH));
  assign w_empty = (w_count == '0);

  // Retire/flush qualification, flush clamping and error detection.
  always_comb begin
    w_retire  = wb_retire & ~pipe_stall & ~w_empty;
    w_flush   = flush & ~pipe_stall;
    w_remain  = w_count - SB_PTR_W'(w_retire);
    w_clamp   = (SB_PTR_W'(flush_cnt) > w_remain);
    w_drop    = '0;
    if (w_flush) w_drop = w_clamp ? w_remain[1:0] : flush_cnt;
    w_err_set = (wb_retire & ~pipe_stall & w_empty) | (w_flush & w_clamp);
  end

  // Source-vs-pending-writer compare; the retiring head is skipped when bypass is built in.
  always_comb begin
    logic w_skip;
    w_skip   = 1'b0;
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_skip = BYPASS & w_retire & (w_head == SB_PTR_W'(i));
      if (w_valid[i] && w_entries[i].wr && !w_skip) begin
        if (src_a_used && (w_entries[i].dest == src_a)) w_hazard = 1'b1;
        if (src_b_used && (w_entries[i].dest == src_b)) w_hazard = 1'b1;
      end
    end
  end

  assign w_issue      = issue_req & ~w_hazard & ~w_full & ~pipe_stall & ~flush;
  assign w_push_entry = '{wr: dest_wr, dest: dest};

  sb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_issue),
    .i_entry   (w_push_entry),
    .i_pop     (w_retire),
    .i_drop    (w_drop),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign issue_ok     = w_issue;
  assign stall_decode = issue_req & ~w_issue;
  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign err          = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_regfile_scoreboard;

  localparam int DEPTH = 3;

`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] src_a, src_b, dest;
  logic       src_a_used, src_b_used, dest_wr;
  logic       issue_req, pipe_stall, wb_retire, flush;
  logic [1:0] flush_cnt;
  logic       issue_ok, stall_decode, full, empty, err;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: in-flight list, oldest at index 0.
  int m_wr[$];
  int m_dest[$];
  bit m_err = 1'b0;

  // Values seen in the most recent step, for directed constant checks.
  logic ob_ok, ob_stall, ob_full, ob_empty, ob_err;
  logic [2:0] ob_cnt;

  regfile_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .src_a(src_a), .src_a_used(src_a_used),
    .src_b(src_b), .src_b_used(src_b_used),
    .dest(dest), .dest_wr(dest_wr),
    .issue_req(issue_req), .pipe_stall(pipe_stall),
    .wb_retire(wb_retire), .flush(flush), .flush_cnt(flush_cnt),
    .issue_ok(issue_ok), .stall_decode(stall_decode),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    src_a = 0; src_b = 0; dest = 0; src_a_used = 0; src_b_used = 0; dest_wr = 0;
    issue_req = 0; pipe_stall = 0; wb_retire = 0; flush = 0; flush_cnt = 0;
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge, advance the model.
  task automatic step(input bit ir, input int sa, input bit sau, input int sb, input bit sbu,
                      input int d, input bit dw, input bit ps, input bit ret,
                      input bit fl, input int fc);
    int  cnt, n;
    bit  hz, ok;
    @(posedge clk); #1;
    issue_req = ir; src_a = 3'(sa); src_a_used = sau; src_b = 3'(sb); src_b_used = sbu;
    dest = 3'(d); dest_wr = dw; pipe_stall = ps; wb_retire = ret; flush = fl; flush_cnt = 2'(fc);
    @(negedge clk);
    cnt = m_wr.size();
    hz  = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (BYP && i == 0 && ret && !ps) continue;
      if (m_wr[i] != 0 && ((sau && m_dest[i] == sa) || (sbu && m_dest[i] == sb))) hz = 1'b1;
    end
    ok = ir && !hz && (cnt != DEPTH) && !ps && !fl;
    ob_ok = issue_ok; ob_stall = stall_decode; ob_cnt = count;
    ob_full = full; ob_empty = empty; ob_err = err;
    chk("issue_ok", issue_ok, ok);
    chk("stall_decode", stall_decode, ir && !ok);
    chk("count", count, cnt);
    chk("full", full, cnt == DEPTH);
    chk("empty", empty, cnt == 0);
    chk("err", err, m_err);
    if (!ps) begin
      if (ret) begin
        if (m_wr.size() == 0) m_err = 1'b1;
        else begin void'(m_wr.pop_front()); void'(m_dest.pop_front()); end
      end
      if (fl) begin
        n = fc;
        if (n > m_wr.size()) begin m_err = 1'b1; n = m_wr.size(); end
        repeat (n) begin void'(m_wr.pop_back()); void'(m_dest.pop_back()); end
      end
    end
    if (ok) begin m_wr.push_back(dw); m_dest.push_back(d); end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && m_wr.size() > 0; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    #10 reset_n = 1'b1;

    // Writer to R1, then a dependent reader.
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("tp_add_issue", ob_ok, 1);
    step(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    chk("tp_cnt1", ob_cnt, 1);
    chk("tp_rd_stall", ob_stall, 1);
    step(1, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0);
    chk("tp_retire_cycle", ob_ok, BYP);
    step(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    chk("tp_after_retire", ob_ok, 1);
    drain();

    // Fill with non-conflicting instructions, then issue against full.
    for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    chk("tp_full", ob_full, 1);
    chk("tp_full_stall", ob_stall, 1);
    step(1, 0, 0, 0, 0, 4, 0, 0, 1, 0, 0);
    chk("tp_full_ret_block", ob_ok, 0);
    idle();
    chk("tp_full_ret_cnt", ob_cnt, DEPTH - 1);
    drain();

    // Two writers to R3, flush the younger one.
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("tp_fl_before", ob_cnt, 2);
    step(1, 0, 0, 3, 1, 5, 1, 0, 0, 0, 0);
    chk("tp_fl_after", ob_cnt, 1);
    chk("tp_r3_blocked", ob_ok, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 3, 1, 5, 1, 0, 0, 0, 0);
    chk("tp_r3_free", ob_ok, 1);
    drain();

    // Over-sized flush together with retire, then retire on empty.
    step(1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    idle();
    chk("tp_clamp_cnt", ob_cnt, 0);
    chk("tp_clamp_err", ob_err, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    chk("tp_empty_ret_cnt", ob_cnt, 0);
    chk("tp_empty_ret_err", ob_err, 1);

    // pipe_stall freezes everything.
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 2, 1, 1, 1, 1, 2);
    chk("tp_stall_ok", ob_ok, 0);
    idle();
    chk("tp_stall_cnt", ob_cnt, 1);

    // Random traffic on a small register window to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 4, $urandom_range(0, 11) == 0, $urandom_range(0, 3));
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_err", err, 0);
    m_wr.delete(); m_dest.delete(); m_err = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    for (int k = 0; k < 100; k++) begin
      step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
